matmul_seq: RTL and testbench
=============================

MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL declare clk input 1: rising-edge clock for all state.
REQ-002 SHALL declare rst input 1: reset, synchronous, active-high.
REQ-003 SHALL declare ld_valid input 1: operand write strobe.
REQ-004 SHALL declare ld_sel input 1: 0 = matrix A, 1 = matrix B.
REQ-005 SHALL declare ld_addr input 4: element index, row-major 0..8 (addr = 3*row + col).
REQ-006 SHALL declare ld_data input 8 signed: element value.
REQ-007 SHALL declare start input 1: begin a 3x3 product A*B.
REQ-008 SHALL declare a_i_0, a_i_1, a_i_2 output 8 signed each: row i of A, to the dot-product unit.
REQ-009 SHALL declare b_j_0, b_j_1, b_j_2 output 8 signed each: column j of B, to the dot-product unit.
REQ-010 SHALL declare w_en output 1: write enable to the dot-product unit.
REQ-011 SHALL declare sop input 16 signed: dot-product result returned by the dot-product unit.
REQ-012 SHALL declare res_valid output 1, res_data output 16 signed, res_idx output 4 (3*i + j), and res_ready input 1: result stream.
REQ-013 SHALL declare busy output 1 (high outside IDLE) and done output 1 (one-cycle pulse).

Function
REQ-014 SHALL store A and B as 9 x 8-bit each; an ld_valid write occurs only in IDLE with ld_addr <= 8; other writes are ignored.
REQ-015 SHALL implement FSM states IDLE, ISSUE, CAPTURE, OUTPUT, DONE.
REQ-016 SHALL leave IDLE for ISSUE on start; start outside IDLE is ignored; on entry i = j = 0.
REQ-017 SHALL, in ISSUE, drive a_i_k = A[i][k] and b_j_k = B[k][j], assert w_en, and go to CAPTURE next cycle.
REQ-018 SHALL, in CAPTURE, hold the operands and w_en unchanged, register sop into res_data, and go to OUTPUT.
REQ-019 SHALL, in OUTPUT, assert res_valid with res_data and res_idx stable until a cycle with res_ready = 1, and w_en shall be 0 in this state.
REQ-020 SHALL, on the OUTPUT handshake, advance j fastest (j wraps 2 -> 0 and increments i) and return to ISSUE, or go to DONE if (i,j) = (2,2).
REQ-021 SHALL, in DONE, pulse done for one cycle, then return to IDLE; stored matrices are retained, so start may immediately run again.
REQ-022 SHALL give a fixed latency: start sampled at cycle t gives first res_valid at t+3; with res_ready held high each result takes 3 cycles, done asserts at t+28, and IDLE is reached at t+29.
REQ-023 SHALL pass sop through unmodified (no saturation); 16-bit wrap is the accepted behaviour of the dot-product unit.
REQ-024 SHALL drive operand outputs to 0 whenever the FSM is in IDLE or DONE.

Reset
REQ-025 SHALL, on rst, go to IDLE, zero i, j, and both matrices, and drive every output to 0 (res_valid, res_data, res_idx, w_en, busy, done, all operands).
REQ-026 SHALL let rst override start and ld_valid in the same cycle; rst during any state aborts the run and emits no further results.

Structure
REQ-027 SHALL place N = 3, DATA_W = 8, SOP_W = 16, and the state enum in the shared package matmul_pkg.
REQ-028 SHALL use one sub-module, mat_store (9 x DATA_W register file with a write port and three parallel read ports), instantiated once for A and once for B.

Verification
REQ-029 SHALL cover identity: A = I, B = 1..9 row-major, res_ready = 1 -> res_data sequence 1..9 with res_idx 0..8, and done at t+28.
REQ-030 SHALL cover signed values: A all -2, B all 3 -> all nine results = -18.
REQ-031 SHALL cover overflow: A and B all -128 -> every result = 49152 wrapped = -16384 (0xC000).
REQ-032 SHALL cover backpressure: res_ready low for 5 cycles on result 4 -> res_valid, res_data, and res_idx = 4 held stable, w_en = 0 throughout, and done delayed by exactly 5 cycles.
REQ-033 SHALL cover reset mid-run: rst asserted during the OUTPUT state of result 2 -> next cycle all outputs are 0, in IDLE, and a new start with re-loaded matrices runs correctly.
REQ-034 SHALL cover ignored inputs: ld_valid during busy, ld_addr = 9 in IDLE, and start during busy -> matrices unchanged and the run unaffected.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and index helper for the sequential
// 3x3 matrix multiplier.
package matmul_pkg;

    localparam int unsigned N      = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SOP_W  = 16;
    localparam int unsigned NELEM  = N * N;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned RC_W   = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_OUTPUT,
        ST_DONE
    } state_e;

    // Row-major element index: 3*row + col.
    function automatic logic [IDX_W-1:0] elem_idx(input logic [RC_W-1:0] row,
                                                  input logic [RC_W-1:0] col);
        return IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/mat_store.sv
// Nine-entry matrix register file: one synchronous write port, three
// asynchronous read ports so a full row or column is available at once.
module mat_store
    import matmul_pkg::*;
#(
    parameter int unsigned W     = DATA_W,
    parameter int unsigned DEPTH = NELEM,
    parameter int unsigned AW    = IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [W-1:0]  rdata0,
    output logic [W-1:0]  rdata1,
    output logic [W-1:0]  rdata2
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/matmul_seq.sv
// Sequential 3x3 matrix multiplier: issues one row/column pair per result to
// an external dot-product unit and streams the nine products out with a handshake.
module matmul_seq
    import matmul_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    input  logic                     ld_sel,
    input  logic [IDX_W-1:0]         ld_addr,
    input  logic signed [DATA_W-1:0] ld_data,
    input  logic                     start,
    output logic signed [DATA_W-1:0] a_i_0,
    output logic signed [DATA_W-1:0] a_i_1,
    output logic signed [DATA_W-1:0] a_i_2,
    output logic signed [DATA_W-1:0] b_j_0,
    output logic signed [DATA_W-1:0] b_j_1,
    output logic signed [DATA_W-1:0] b_j_2,
    output logic                     w_en,
    input  logic signed [SOP_W-1:0]  sop,
    output logic                     res_valid,
    output logic signed [SOP_W-1:0]  res_data,
    output logic [IDX_W-1:0]         res_idx,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done
);

    state_e                  state_q, state_d;
    logic [RC_W-1:0]         i_q, i_d;
    logic [RC_W-1:0]         j_q, j_d;
    logic signed [SOP_W-1:0] res_q, res_d;

    logic                    wr_ok;
    logic                    op_en;
    logic [DATA_W-1:0]       a_rd0, a_rd1, a_rd2;
    logic [DATA_W-1:0]       b_rd0, b_rd1, b_rd2;

    // Operand loads are accepted only while idle and in range.
    assign wr_ok = (state_q == ST_IDLE) && ld_valid && (ld_addr <= LAST_IDX);

    mat_store #(
        .W     (DATA_W),
        .DEPTH (NELEM),
        .AW    (IDX_W)
    ) u_mat_a (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_ok && !ld_sel),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr0 (elem_idx(i_q, 2'd0)),
        .raddr1 (elem_idx(i_q, 2'd1)),
        .raddr2 (elem_idx(i_q, 2'd2)),
        .rdata0 (a_rd0),
        .rdata1 (a_rd1),
        .rdata2 (a_rd2)
    );

    // B is read column-wise: entries B[k][j] for k = 0..2.
    mat_store #(
        .W     (DATA_W),
        .DEPTH (NELEM),
        .AW    (IDX_W)
    ) u_mat_b (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_ok && ld_sel),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr0 (elem_idx(2'd0, j_q)),
        .raddr1 (elem_idx(2'd1, j_q)),
        .raddr2 (elem_idx(2'd2, j_q)),
        .rdata0 (b_rd0),
        .rdata1 (b_rd1),
        .rdata2 (b_rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_d   = sop;
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    if ((i_q == LAST_RC) && (j_q == LAST_RC)) begin
                        state_d = ST_DONE;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        if (j_q == LAST_RC) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        op_en     = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);
        w_en      = op_en;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        res_valid = (state_q == ST_OUTPUT);
        res_data  = res_q;
        res_idx   = elem_idx(i_q, j_q);
        a_i_0     = op_en ? a_rd0 : '0;
        a_i_1     = op_en ? a_rd1 : '0;
        a_i_2     = op_en ? a_rd2 : '0;
        b_j_0     = op_en ? b_rd0 : '0;
        b_j_1     = op_en ? b_rd1 : '0;
        b_j_2     = op_en ? b_rd2 : '0;
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Randomized self-checking bench for matmul_seq; the bench also plays the
// external dot-product unit.
module tb_matmul_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid;
    logic              ld_sel;
    logic [3:0]        ld_addr;
    logic signed [7:0] ld_data;
    logic              start;
    logic signed [7:0] a_i_0, a_i_1, a_i_2;
    logic signed [7:0] b_j_0, b_j_1, b_j_2;
    logic              w_en;
    logic signed [15:0] sop;
    logic              res_valid;
    logic signed [15:0] res_data;
    logic [3:0]        res_idx;
    logic              res_ready;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    int ref_a [9];
    int ref_b [9];

    logic signed [7:0] av [3];
    logic signed [7:0] bv [3];

    matmul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .a_i_0     (a_i_0),
        .a_i_1     (a_i_1),
        .a_i_2     (a_i_2),
        .b_j_0     (b_j_0),
        .b_j_1     (b_j_1),
        .b_j_2     (b_j_2),
        .w_en      (w_en),
        .sop       (sop),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Dot-product unit stand-in: combinational, wraps to 16 bits.
    always_comb begin
        av[0] = a_i_0; av[1] = a_i_1; av[2] = a_i_2;
        bv[0] = b_j_0; bv[1] = b_j_1; bv[2] = b_j_2;
        sop = 16'(int'(a_i_0) * int'(b_j_0) + int'(a_i_1) * int'(b_j_1)
                  + int'(a_i_2) * int'(b_j_2));
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_res(input int r);
        int s;
        logic signed [15:0] w;
        s = 0;
        for (int k = 0; k < 3; k++) s += ref_a[3 * (r / 3) + k] * ref_b[3 * k + r % 3];
        w = 16'(s);
        return int'(w);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_wen"},   w_en, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_data"},  res_data, 0);
        check({tag, "_idx"},   res_idx, 0);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_a"}, av[k], 0);
            check({tag, "_b"}, bv[k], 0);
        end
    endtask

    task automatic load(input bit sel, input int addr, input int val);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 4'(addr);
        ld_data  = 8'(val);
        tick();
        ld_valid = 1'b0;
        if (addr < 9) begin
            if (sel) ref_b[addr] = val;
            else     ref_a[addr] = val;
        end
    endtask

    task automatic load_all(input int a [9], input int b [9]);
        for (int e = 0; e < 9; e++) load(1'b0, e, a[e]);
        for (int e = 0; e < 9; e++) load(1'b1, e, b[e]);
    endtask

    task automatic check_ops(input string tag, input int r);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_a"}, av[k], ref_a[3 * (r / 3) + k]);
            check({tag, "_b"}, bv[k], ref_b[3 * k + r % 3]);
        end
    endtask

    // One full product; the bench follows the expected schedule cycle by cycle.
    task automatic run(input int stall_res, input int stall_len, input bit rnd_rdy,
                       input bit poke, input int abort_res);
        int  cyc;
        int  stalls;
        bit  rdy;
        cyc    = 0;
        stalls = 0;
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        for (int r = 0; r < 9; r++) begin
            if (poke && r == 1) begin
                ld_valid = 1'b1;
                ld_sel   = 1'($urandom_range(0, 1));
                ld_addr  = 4'($urandom_range(0, 8));
                ld_data  = 8'($urandom);
                start    = 1'b1;
            end
            check("issue_wen", w_en, 1);
            check("issue_busy", busy, 1);
            check("issue_valid", res_valid, 0);
            check_ops("issue", r);
            tick(); cyc++;
            ld_valid = 1'b0;
            start    = 1'b0;
            check("capt_wen", w_en, 1);
            check("capt_valid", res_valid, 0);
            check_ops("capt", r);
            tick(); cyc++;
            for (int s = 0; s < 64; s++) begin
                check("out_valid", res_valid, 1);
                check("out_wen", w_en, 0);
                check("out_idx", res_idx, r);
                check("out_data", res_data, exp_res(r));
                if (r == abort_res) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    for (int e = 0; e < 9; e++) begin
                        ref_a[e] = 0;
                        ref_b[e] = 0;
                    end
                    check_zero("abort");
                    return;
                end
                if (r == stall_res && s < stall_len) rdy = 1'b0;
                else if (rnd_rdy && s < 40)          rdy = ($urandom_range(0, 3) != 0);
                else                                 rdy = 1'b1;
                res_ready = rdy;
                tick(); cyc++;
                if (rdy) break;
                stalls++;
            end
            res_ready = 1'b1;
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", res_valid, 0);
        check("done_cycle", cyc, 28 + stalls);
        for (int k = 0; k < 3; k++) begin
            check("done_a", av[k], 0);
            check("done_b", bv[k], 0);
        end
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_wen", w_en, 0);
        check("idle_a0", av[0], 0);
    endtask

    initial begin
        int ma [9];
        int mb [9];
        rst = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'sd5;
        start = 1'b1; res_ready = 1'b0;
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = 0;
            ref_b[e] = 0;
        end
        tick(); tick();
        rst = 1'b0; ld_valid = 1'b0; start = 1'b0;
        check_zero("reset");

        // Identity times 1..9
        for (int e = 0; e < 9; e++) begin
            ma[e] = (e % 4 == 0) ? 1 : 0;
            mb[e] = e + 1;
        end
        load_all(ma, mb);
        run(-1, 0, 1'b0, 1'b0, -1);
        // Immediate rerun, out-of-range load, loads/start while busy
        load(1'b0, 9, 77);
        run(-1, 0, 1'b0, 1'b1, -1);

        for (int e = 0; e < 9; e++) begin ma[e] = -2; mb[e] = 3; end
        load_all(ma, mb);
        run(-1, 0, 1'b0, 1'b0, -1);

        for (int e = 0; e < 9; e++) begin ma[e] = -128; mb[e] = -128; end
        load_all(ma, mb);
        run(-1, 0, 1'b0, 1'b0, -1);
        check("ovf_ref", exp_res(0), -16384);

        // Backpressure on result 4
        for (int e = 0; e < 9; e++) begin ma[e] = rnd8(); mb[e] = rnd8(); end
        load_all(ma, mb);
        run(4, 5, 1'b0, 1'b0, -1);

        // Reset while result 2 is presented, then reload and rerun
        run(-1, 0, 1'b0, 1'b0, 2);
        for (int e = 0; e < 9; e++) begin ma[e] = rnd8(); mb[e] = rnd8(); end
        load_all(ma, mb);
        run(-1, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            for (int e = 0; e < 9; e++) begin ma[e] = rnd8(); mb[e] = rnd8(); end
            load_all(ma, mb);
            run(-1, 0, 1'b1, (t % 2) == 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
